fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  PC generator and IF-stage control that sits directly upstream of instructionmem.
//  Drives the byte address into instructionmem and tracks which PC each returning word belongs to.
//  instructionmem has 1 cycle of registered read latency.
//  Presents a tagged, valid-qualified instruction to decode.
//  Handles stall (replay), branch/jump redirect (flush) and address-range checks.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC fetched first after reset release (word aligned)
//  IMEM_BYTES 256            instruction memory size in bytes; power of 2, >= 8
// PORTS
//  clk             in   1   core clock, all state on posedge
//  reset           in   1   asynchronous, active-low reset (0 = in reset)
//  stall_i         in   1   decode cannot accept: hold current IF instruction
//  redirect_i      in   1   taken branch/jump from execute
//  redirect_pc_i   in   32  redirect target byte address
//  imem_instr_i    in   32  instructionmem.instruction (word for PC issued last cycle)
//  imem_pc_o       out  32  instructionmem.pc (combinational)
//  if_valid_o      out  1   if_pc_o/if_instr_o hold a real instruction
//  if_pc_o         out  32  PC of if_instr_o
//  if_instr_o      out  32  instruction to decode; 32'h0000_0013 (NOP) when !if_valid_o
//  misalign_o      out  1   1-cycle pulse: redirect target had [1:0]!=0
//  range_err_o     out  1   1-cycle pulse: redirect target >= IMEM_BYTES
//  fetch_count_o   out  32  instructions delivered to decode, wraps at 2^32
// BEHAVIOUR
//  Regs: fetch_pc_q (next PC to issue), infl_pc_q (PC of word on imem_instr_i), infl_v_q, state_q.
//  Reset (async, reset=0): fetch_pc_q=RESET_PC, infl_pc_q=0, infl_v_q=0, state=BOOT.
//   Outputs: if_valid_o=0, if_pc_o=0, if_instr_o=NOP, misalign_o=0, range_err_o=0, fetch_count_o=0.
//   Reset asserted mid-operation aborts everything immediately; no pending state survives.
//  imem_pc_o = (stall_i && !redirect_i && infl_v_q) ? infl_pc_q : fetch_pc_q.
//   During a stall the held PC is replayed, so imem_instr_i stays equal to the held instruction.
//  if_valid_o=infl_v_q; if_pc_o=infl_pc_q; if_instr_o=infl_v_q ? imem_instr_i : NOP.
//  Per-cycle update, in priority order:
//   1 redirect_i:
//     - fetch_pc_q <= {redirect_pc_i[31:2],2'b00} mod IMEM_BYTES; infl_v_q <= 0.
//     - state -> REDIR.
//     - misalign_o <= |redirect_pc_i[1:0]; range_err_o <= (redirect_pc_i >= IMEM_BYTES).
//   2 stall_i (no redirect): hold fetch_pc_q, infl_pc_q, infl_v_q; state -> STALL.
//   3 else (advance):
//     - infl_pc_q <= fetch_pc_q; infl_v_q <= 1.
//     - fetch_pc_q <= (fetch_pc_q+4) mod IMEM_BYTES; state -> RUN.
//  misalign_o/range_err_o are 0 in every cycle not following a redirect.
//  States:
//   BOOT  = first cycle after release; no valid output.
//   RUN   = streaming.
//   STALL = holding.
//   REDIR = 1-cycle bubble after a flush; the wrong-path word is discarded.
//   Transitions into all states follow the priority rules above.
//   BOOT and REDIR always last exactly 1 cycle unless stall or redirect repeats.
//  Latency:
//   - issue-to-if_valid: 1 cycle.
//   - redirect-to-first-target-instruction: 2 cycles (1 bubble).
//  fetch_count_o increments when if_valid_o && !stall_i && !redirect_i.
//  Boundaries:
//   - sequential PC wraps IMEM_BYTES-4 -> 0.
//   - redirect+stall in the same cycle: redirect wins.
//   - stall during BOOT/REDIR: stays invalid and issues fetch_pc_q.
//   - back-to-back redirects: the last one wins and each adds a bubble.
// TESTING
//  1 Release reset, no stall: imem_pc_o 0,4,8..; if_valid_o 0 in cycle 0.
//    Then if_pc_o 0,4,8 with matching words; fetch_count_o counts 1,2,3.
//  2 stall_i=1 for 3 cycles while if_pc_o=8: if_pc_o=8, imem_pc_o=8 and if_instr_o stable.
//    Count frozen; after release if_pc_o=12 next cycle.
//  3 redirect_i with redirect_pc_i=0x40 while if_pc_o=4: next cycle if_valid_o=0 and if_instr_o=NOP.
//    Following cycle if_pc_o=0x40.
//  4 redirect_pc_i=0x42: misalign_o=1 for one cycle; fetch resumes at 0x40.
//    redirect_pc_i=0x100: range_err_o=1; fetch resumes at 0x00.
//  5 Free-run past 0xFC: if_pc_o 0xF8,0xFC,0x00,0x04; no error pulses.
//  6 redirect_i and stall_i same cycle -> redirect taken.
//    reset=0 mid-stall -> all outputs at reset values in the same cycle; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC generator and IF-stage control in front of instructionmem.
// Issues byte addresses to the memory, tracks which PC each returning word
// belongs to (one cycle of registered read latency), and presents a tagged,
// valid-qualified instruction to decode. Handles stall (replay), redirect
// (flush with a one-cycle bubble) and redirect-target range/alignment checks.
`timescale 1ns/1ps

module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] imem_pc_o,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic        misalign_o,
    output logic        range_err_o,
    output logic [31:0] fetch_count_o
);

    localparam logic [31:0] NOP        = 32'h0000_0013;
    // IMEM_BYTES is a power of two, so "mod IMEM_BYTES" is a mask.
    localparam logic [31:0] ADDR_MASK  = 32'(IMEM_BYTES - 1);
    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        REDIR = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] fetch_pc_q;
    logic [31:0] fetch_pc_d;
    logic [31:0] infl_pc_q;
    logic [31:0] infl_pc_d;
    logic        infl_v_q;
    logic        infl_v_d;
    logic        misalign_q;
    logic        misalign_d;
    logic        range_err_q;
    logic        range_err_d;
    logic [31:0] fetch_count_q;

    logic        replay;
    logic        deliver;
    logic [31:0] seq_pc;
    logic [31:0] redir_pc;

    // A stall with a live instruction re-reads its PC so the memory output
    // keeps presenting the held word; a redirect always overrides the replay.
    assign replay   = stall_i && !redirect_i && infl_v_q;
    assign deliver  = infl_v_q && !stall_i && !redirect_i;
    assign seq_pc   = (fetch_pc_q + 32'd4) & ADDR_MASK;
    assign redir_pc = {redirect_pc_i[31:2], 2'b00} & ADDR_MASK;

    assign imem_pc_o     = replay ? infl_pc_q : fetch_pc_q;
    assign if_valid_o    = infl_v_q;
    assign if_pc_o       = infl_pc_q;
    assign if_instr_o    = infl_v_q ? imem_instr_i : NOP;
    // Error flags are only ever loaded by a redirect, which always lands in
    // REDIR, so qualifying with the state keeps them strictly one-cycle pulses.
    assign misalign_o    = misalign_q && (state_q == REDIR);
    assign range_err_o   = range_err_q && (state_q == REDIR);
    assign fetch_count_o = fetch_count_q;

    // Next-state and next-register selection: redirect > stall > advance.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        infl_pc_d   = infl_pc_q;
        infl_v_d    = infl_v_q;
        misalign_d  = 1'b0;
        range_err_d = 1'b0;

        if (redirect_i) begin
            // Flush: the word coming back next cycle is wrong-path, drop it.
            state_d     = REDIR;
            fetch_pc_d  = redir_pc;
            infl_v_d    = 1'b0;
            misalign_d  = |redirect_pc_i[1:0];
            range_err_d = (redirect_pc_i >= IMEM_LIMIT);
        end else if (stall_i) begin
            state_d = STALL;
        end else begin
            state_d    = RUN;
            infl_pc_d  = fetch_pc_q;
            infl_v_d   = 1'b1;
            fetch_pc_d = seq_pc;
        end
    end

    // State and PC-tracking registers; reset aborts any in-flight fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= BOOT;
            fetch_pc_q  <= RESET_PC;
            infl_pc_q   <= 32'd0;
            infl_v_q    <= 1'b0;
            misalign_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            infl_pc_q   <= infl_pc_d;
            infl_v_q    <= infl_v_d;
            misalign_q  <= misalign_d;
            range_err_q <= range_err_d;
        end
    end

    // Count instructions actually accepted by decode; wraps naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= 32'd0;
        end else if (deliver) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios with literal expectations,
// then randomized stall/redirect/reset traffic checked every cycle against a
// behavioural model of the fetch pipeline and a model instruction memory.
`timescale 1ns/1ps

module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          MEM    = 256;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] imem_instr;
    logic [31:0] imem_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign;
    logic        range_err;
    logic [31:0] fetch_count;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [31:0] m_next_pc;      // next address the fetch unit will request
    logic [31:0] m_held_pc;      // PC of instruction presented to decode
    logic        m_held_v;
    logic        m_mis;
    logic        m_rng;
    logic [31:0] delivered[$];   // PCs accepted by decode since reset

    fetch_stage #(.RESET_PC(RST_PC), .IMEM_BYTES(MEM)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall),
        .redirect_i    (redir),
        .redirect_pc_i (rpc),
        .imem_instr_i  (imem_instr),
        .imem_pc_o     (imem_pc),
        .if_valid_o    (if_valid),
        .if_pc_o       (if_pc),
        .if_instr_o    (if_instr),
        .misalign_o    (misalign),
        .range_err_o   (range_err),
        .fetch_count_o (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hC0DE_0000 ^ (a * 32'd97) ^ {a[7:0], 24'h000001};
    endfunction

    // Model instruction memory: one cycle of registered read latency.
    always @(posedge clk) imem_instr <= word_at(imem_pc % MEM);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_next_pc = RST_PC;
        m_held_pc = 32'd0;
        m_held_v  = 1'b0;
        m_mis     = 1'b0;
        m_rng     = 1'b0;
        delivered.delete();
    endtask

    // Compare all outputs against the model for the currently applied inputs.
    task automatic compare_all();
        logic [31:0] exp_pc;
        exp_pc = (stall && !redir && m_held_v) ? m_held_pc : m_next_pc;
        chk("imem_pc", imem_pc, exp_pc);
        chk("if_valid", {31'd0, if_valid}, {31'd0, m_held_v});
        chk("if_pc", if_pc, m_held_pc);
        chk("if_instr", if_instr, m_held_v ? word_at(m_held_pc) : NOP);
        chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
        chk("range_err", {31'd0, range_err}, {31'd0, m_rng});
        chk("fetch_count", fetch_count, 32'(delivered.size()));
    endtask

    // What the clock edge does, from the behavioural rules.
    task automatic model_edge();
        m_mis = 1'b0;
        m_rng = 1'b0;
        if (redir) begin
            m_next_pc = {rpc[31:2], 2'b00} % MEM;
            m_held_v  = 1'b0;
            m_mis     = (rpc % 4) != 0;
            m_rng     = rpc >= MEM;
        end else if (!stall) begin
            if (m_held_v) delivered.push_back(m_held_pc);
            m_held_pc = m_next_pc;
            m_held_v  = 1'b1;
            m_next_pc = (m_next_pc + 4) % MEM;
        end
    endtask

    // One clock cycle: apply inputs, check outputs, advance model.
    task automatic cycle(input logic s, input logic r, input logic [31:0] p);
        @(negedge clk);
        stall = s;
        redir = r;
        rpc   = p;
        #1;
        compare_all();
        model_edge();
    endtask

    // Asynchronous reset mid-cycle; outputs must drop immediately.
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_imem_pc", imem_pc, RST_PC);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, NOP);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_range_err", {31'd0, range_err}, 32'd0);
        chk("rst_fetch_count", fetch_count, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] tgt;
        int          sel;
        reset = 1'b0;
        stall = 1'b0;
        redir = 1'b0;
        rpc   = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("init_if_valid", {31'd0, if_valid}, 32'd0);
        chk("init_if_instr", if_instr, NOP);
        chk("init_imem_pc", imem_pc, RST_PC);
        chk("init_fetch_count", fetch_count, 32'd0);
        #1 reset = 1'b1;

        // Sequential fetch after release
        cycle(0, 0, 0);
        chk("boot_valid", {31'd0, if_valid}, 32'd0);
        chk("boot_imem_pc", imem_pc, 32'h00);
        cycle(0, 0, 0);
        chk("seq_pc0", if_pc, 32'h00);
        chk("seq_imem4", imem_pc, 32'h04);
        chk("seq_cnt0", fetch_count, 32'd0);
        cycle(0, 0, 0);
        chk("seq_pc4", if_pc, 32'h04);
        chk("seq_cnt1", fetch_count, 32'd1);

        // Stall for three cycles while PC 8 is presented
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0);
            chk("stall_if_pc", if_pc, 32'h08);
            chk("stall_imem_pc", imem_pc, 32'h08);
            chk("stall_instr", if_instr, word_at(32'h08));
            chk("stall_cnt", fetch_count, 32'd2);
        end
        cycle(0, 0, 0);
        chk("unstall_pc8", if_pc, 32'h08);
        cycle(0, 1, 32'h40);
        chk("after_stall_pc12", if_pc, 32'h0C);
        chk("after_stall_cnt", fetch_count, 32'd3);

        // Redirect bubble then target
        cycle(0, 0, 0);
        chk("bubble_valid", {31'd0, if_valid}, 32'd0);
        chk("bubble_instr", if_instr, NOP);
        chk("bubble_imem", imem_pc, 32'h40);
        cycle(0, 1, 32'h42);
        chk("target_pc40", if_pc, 32'h40);
        cycle(0, 1, 32'h100);
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        chk("mis_rng0", {31'd0, range_err}, 32'd0);
        chk("mis_imem", imem_pc, 32'h40);
        cycle(0, 0, 0);
        chk("rng_pulse", {31'd0, range_err}, 32'd1);
        chk("rng_mis0", {31'd0, misalign}, 32'd0);
        chk("rng_imem", imem_pc, 32'h00);
        cycle(0, 1, 32'hF8);
        chk("rng_resume0", if_pc, 32'h00);
        chk("rng_cleared", {31'd0, range_err}, 32'd0);

        // Wrap past the top of memory
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("wrap_F8", if_pc, 32'hF8);
        cycle(0, 0, 0);
        chk("wrap_FC", if_pc, 32'hFC);
        chk("wrap_imem0", imem_pc, 32'h00);
        cycle(0, 0, 0);
        chk("wrap_00", if_pc, 32'h00);
        cycle(0, 0, 0);
        chk("wrap_04", if_pc, 32'h04);
        chk("wrap_noerr", {30'd0, misalign, range_err}, 32'd0);

        // Redirect and stall together: redirect wins, stall in bubble
        cycle(1, 1, 32'h80);
        cycle(1, 0, 0);
        chk("rs_valid", {31'd0, if_valid}, 32'd0);
        chk("rs_imem", imem_pc, 32'h80);
        cycle(0, 0, 0);
        chk("rs_still_invalid", {31'd0, if_valid}, 32'd0);
        cycle(1, 0, 0);
        chk("rs_pc80", if_pc, 32'h80);
        cycle(1, 0, 0);
        do_reset();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("restart_pc", if_pc, RST_PC);

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                sel = $urandom_range(0, 9);
                if (sel == 0)      tgt = $urandom;
                else if (sel == 1) tgt = 32'(MEM) + $urandom_range(0, 255);
                else               tgt = $urandom_range(0, MEM - 1);
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tgt);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
